// File: rtl/psram_pkg.sv
// Shared types and sizes for the PSRAM DMA task scheduler.
package psram_pkg;

    localparam int TASK_N  = 8;
    localparam int IDX_W   = 3;
    localparam int TADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        BUSY = 2'd3
    } sched_state_t;

    function automatic logic [TASK_N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return {{(TASK_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after the pointer, wrapping.
module psram_rr_arb
    import psram_pkg::*;
(
    input  logic [TASK_N-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit overwrites earlier ones.
    always_comb begin
        gnt_idx   = {IDX_W{1'b0}};
        gnt_valid = 1'b0;
        cand      = {IDX_W{1'b0}};
        for (int k = TASK_N - 1; k >= 0; k--) begin
            cand      = ptr + IDX_W'(k);
            gnt_idx   = req[cand] ? cand : gnt_idx;
            gnt_valid = req[cand] | gnt_valid;
        end
    end

endmodule

// File: rtl/psram_task_sched.sv
// PSRAM DMA task scheduler: task list edits, per-task trigger latching, round-robin
// dispatch of descriptor requests to the engine and sticky per-task completion status.
module psram_task_sched
    import psram_pkg::*;
#(
    parameter int TRIG_N     = 16,
    parameter int DESC_BYTES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dma_en,
    input  logic               task_load,
    input  logic               task_add,
    input  logic               task_remove,
    input  logic [7:0]         task_val,
    input  logic [2:0]         task_max,
    input  logic [16:0]        task_table_addr,
    input  logic [31:0]        task_trig,
    input  logic [TRIG_N-1:0]  trig_in,
    input  logic [7:0]         irq_en,
    input  logic [7:0]         irq_clr,
    output logic [7:0]         task_list,
    output logic [7:0]         irq_status,
    output logic               irq,
    output logic               task_req,
    output logic [2:0]         task_idx,
    output logic [16:0]        task_desc_addr,
    input  logic               task_ack,
    input  logic               task_done
);

    localparam int DESC_SHIFT = $clog2(DESC_BYTES);

    sched_state_t          state_q, state_d;
    logic [TASK_N-1:0]     task_list_q, task_list_d;
    logic [TASK_N-1:0]     pending_q, pending_d;
    logic [TASK_N-1:0]     irq_status_q, irq_status_d;
    logic                  irq_q;
    logic                  task_req_q;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      task_idx_q, task_idx_d;
    logic [TADDR_W-1:0]    task_desc_addr_q, task_desc_addr_d;
    logic                  load_hist_q, add_hist_q, remove_hist_q;
    logic [TRIG_N-1:0]     trig_prev_q;

    logic                  load_rise, add_rise, remove_rise;
    logic [15:0]           trig_rise_pad;
    logic [TASK_N-1:0]     max_mask, fire, eligible;
    logic [TASK_N-1:0]     ack_mask, remove_mask, done_set;
    logic                  ack_accept;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;

    function automatic logic [TADDR_W-1:0] desc_addr(input logic [TADDR_W-1:0] base,
                                                     input logic [IDX_W-1:0]   idx);
        return base + (TADDR_W'(idx) << DESC_SHIFT);
    endfunction

    assign load_rise   = task_load   & ~load_hist_q;
    assign add_rise    = task_add    & ~add_hist_q;
    assign remove_rise = task_remove & ~remove_hist_q;

    // Trigger edges, padded to 16 so selects at or above TRIG_N read a constant zero.
    always_comb begin
        trig_rise_pad               = 16'h0000;
        trig_rise_pad[TRIG_N-1:0]   = trig_in & ~trig_prev_q;
        max_mask                    = {TASK_N{1'b0}};
        fire                        = {TASK_N{1'b0}};
        for (int i = 0; i < TASK_N; i++) begin
            max_mask[i] = (IDX_W'(i) <= task_max);
            fire[i]     = trig_rise_pad[task_trig[4*i +: 4]] & task_list_q[i] & max_mask[i];
        end
    end

    assign eligible = pending_q & task_list_q & max_mask;

    psram_rr_arb u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Task list edits: one edit per cycle, load over remove over add.
    always_comb begin
        task_list_d = task_list_q;
        if (load_rise) begin
            task_list_d = task_val;
        end else if (remove_rise) begin
            task_list_d = task_list_q & ~task_val;
        end else if (add_rise) begin
            task_list_d = task_list_q | task_val;
        end else begin
            task_list_d = task_list_q;
        end
    end

    // Pending and status updates; a fresh edge on the ack cycle re-arms the task.
    always_comb begin
        ack_accept   = (state_q == REQ) & task_ack;
        ack_mask     = ack_accept ? idx_onehot(task_idx_q) : {TASK_N{1'b0}};
        remove_mask  = (remove_rise & ~load_rise) ? task_val : {TASK_N{1'b0}};
        pending_d    = ((pending_q & ~ack_mask) | fire) & ~remove_mask;
        done_set     = ((state_q == BUSY) & task_done) ? idx_onehot(task_idx_q) : {TASK_N{1'b0}};
        irq_status_d = (irq_status_q & ~irq_clr) | done_set;
    end

    // Dispatch FSM; an ack seen while the request is still visible is always honoured.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        task_idx_d       = task_idx_q;
        task_desc_addr_d = task_desc_addr_q;
        case (state_q)
            IDLE: begin
                if (dma_en && (|eligible)) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                if (gnt_valid) begin
                    state_d          = REQ;
                    task_idx_d       = gnt_idx;
                    task_desc_addr_d = desc_addr(task_table_addr, gnt_idx);
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (task_ack) begin
                    state_d  = BUSY;
                    rr_ptr_d = task_idx_q + 3'd1;
                end else if (!dma_en || !task_list_d[task_idx_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            BUSY: begin
                if (task_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            task_list_q      <= 8'h00;
            pending_q        <= 8'h00;
            irq_status_q     <= 8'h00;
            irq_q            <= 1'b0;
            task_req_q       <= 1'b0;
            rr_ptr_q         <= 3'd0;
            task_idx_q       <= 3'd0;
            task_desc_addr_q <= 17'h00000;
            load_hist_q      <= 1'b0;
            add_hist_q       <= 1'b0;
            remove_hist_q    <= 1'b0;
            trig_prev_q      <= {TRIG_N{1'b0}};
        end else begin
            state_q          <= state_d;
            task_list_q      <= task_list_d;
            pending_q        <= pending_d;
            irq_status_q     <= irq_status_d;
            irq_q            <= |(irq_status_q & irq_en);
            task_req_q       <= (state_d == REQ);
            rr_ptr_q         <= rr_ptr_d;
            task_idx_q       <= task_idx_d;
            task_desc_addr_q <= task_desc_addr_d;
            load_hist_q      <= task_load;
            add_hist_q       <= task_add;
            remove_hist_q    <= task_remove;
            trig_prev_q      <= trig_in;
        end
    end

    assign task_list      = task_list_q;
    assign irq_status     = irq_status_q;
    assign irq            = irq_q;
    assign task_req       = task_req_q;
    assign task_idx       = task_idx_q;
    assign task_desc_addr = task_desc_addr_q;

endmodule

// File: tb/tb_psram_task_sched.sv
// Directed self-checking bench for psram_task_sched with hand-computed expectations.
module tb_psram_task_sched;

    logic        clk = 1'b0;
    logic        rst, dma_en, task_load, task_add, task_remove;
    logic [7:0]  task_val, irq_en, irq_clr, task_list, irq_status;
    logic [2:0]  task_max, task_idx;
    logic [16:0] task_table_addr, task_desc_addr;
    logic [31:0] task_trig;
    logic [15:0] trig_in;
    logic        irq, task_req, task_ack, task_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psram_task_sched dut (
        .clk(clk), .rst(rst), .dma_en(dma_en),
        .task_load(task_load), .task_add(task_add), .task_remove(task_remove),
        .task_val(task_val), .task_max(task_max), .task_table_addr(task_table_addr),
        .task_trig(task_trig), .trig_in(trig_in), .irq_en(irq_en), .irq_clr(irq_clr),
        .task_list(task_list), .irq_status(irq_status), .irq(irq),
        .task_req(task_req), .task_idx(task_idx), .task_desc_addr(task_desc_addr),
        .task_ack(task_ack), .task_done(task_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig(input logic [15:0] m);
        trig_in = m;
        tick();
        trig_in = 16'h0000;
    endtask

    task automatic wait_req(input int max_cycles);
        for (int i = 0; i < max_cycles && !task_req; i++) tick();
        check_eq("req_seen", {31'd0, task_req}, 32'd1);
    endtask

    task automatic serve(input logic [2:0] exp_idx);
        wait_req(20);
        check_eq("srv_idx", {29'd0, task_idx}, {29'd0, exp_idx});
        task_ack = 1'b1;
        tick();
        task_ack  = 1'b0;
        task_done = 1'b1;
        tick();
        task_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dma_en = 1'b0; task_load = 1'b0; task_add = 1'b0; task_remove = 1'b0;
        task_val = 8'h00; task_max = 3'd7; task_table_addr = 17'h00100;
        task_trig = 32'h8765_4310; trig_in = 16'h0000;
        irq_en = 8'h00; irq_clr = 8'h00; task_ack = 1'b0; task_done = 1'b0;
        repeat (3) tick();
        check_eq("rst_list", {24'd0, task_list}, 32'h0);
        check_eq("rst_status", {24'd0, irq_status}, 32'h0);
        check_eq("rst_irq", {31'd0, irq}, 32'h0);
        check_eq("rst_req", {31'd0, task_req}, 32'h0);
        check_eq("rst_idx", {29'd0, task_idx}, 32'h0);
        check_eq("rst_addr", {15'd0, task_desc_addr}, 32'h0);
        rst = 1'b0;
        tick();

        // list edits; held levels must not re-apply
        task_val = 8'h05; task_load = 1'b1; tick();
        check_eq("load", {24'd0, task_list}, 32'h05);
        task_val = 8'h02; tick();
        check_eq("load_level", {24'd0, task_list}, 32'h05);
        task_load = 1'b0; task_add = 1'b1; tick();
        check_eq("add", {24'd0, task_list}, 32'h07);
        task_add = 1'b0; task_val = 8'h01; task_remove = 1'b1; tick();
        check_eq("remove", {24'd0, task_list}, 32'h06);
        task_remove = 1'b0; task_val = 8'h1F; task_load = 1'b1; tick();
        task_load = 1'b0;
        check_eq("load_1f", {24'd0, task_list}, 32'h1F);

        // minimum latency dispatch of task 2 via trigger 3
        dma_en = 1'b1;
        pulse_trig(16'h0008);
        check_eq("lat_n1", {31'd0, task_req}, 32'h0);
        tick();
        check_eq("lat_n2", {31'd0, task_req}, 32'h0);
        tick();
        check_eq("lat_n3", {31'd0, task_req}, 32'h1);
        check_eq("t2_idx", {29'd0, task_idx}, 32'd2);
        check_eq("t2_addr", {15'd0, task_desc_addr}, 32'h140);
        task_ack = 1'b1; tick(); task_ack = 1'b0;
        check_eq("ack_drop", {31'd0, task_req}, 32'h0);
        task_done = 1'b1; tick(); task_done = 1'b0;
        check_eq("t2_status", {24'd0, irq_status}, 32'h04);

        // set rr_ptr to 2 by serving task 1, then clear status
        pulse_trig(16'h0002);
        serve(3'd1);
        irq_clr = 8'hFF; tick(); irq_clr = 8'h00;
        check_eq("clr_all", {24'd0, irq_status}, 32'h0);

        // tasks 0,1,3 pending together with rr_ptr=2
        pulse_trig(16'h0013);
        serve(3'd3);
        serve(3'd0);
        serve(3'd1);
        check_eq("rr_status", {24'd0, irq_status}, 32'h0B);

        // irq and done-over-clear priority
        irq_en = 8'h08; tick();
        check_eq("irq_on", {31'd0, irq}, 32'h1);
        pulse_trig(16'h0010);
        wait_req(20);
        check_eq("t3_idx", {29'd0, task_idx}, 32'd3);
        task_ack = 1'b1; tick(); task_ack = 1'b0;
        task_done = 1'b1; irq_clr = 8'h08; tick(); task_done = 1'b0;
        check_eq("done_wins", {24'd0, irq_status}, 32'h0B);
        tick();
        check_eq("clr_held", {24'd0, irq_status}, 32'h03);
        check_eq("irq_lag", {31'd0, irq}, 32'h1);
        tick();
        check_eq("irq_off", {31'd0, irq}, 32'h0);
        irq_clr = 8'h00; irq_en = 8'h00;

        // dma_en drop during REQ withdraws, pending survives
        pulse_trig(16'h0001);
        wait_req(20);
        check_eq("t0_idx", {29'd0, task_idx}, 32'd0);
        dma_en = 1'b0; tick();
        check_eq("withdraw", {31'd0, task_req}, 32'h0);
        repeat (3) tick();
        check_eq("no_arb_off", {31'd0, task_req}, 32'h0);
        dma_en = 1'b1;
        wait_req(20);
        check_eq("reen_idx", {29'd0, task_idx}, 32'd0);
        serve(3'd0);

        // task_done outside BUSY is ignored
        irq_clr = 8'hFF; tick(); irq_clr = 8'h00;
        task_done = 1'b1; tick(); task_done = 1'b0; tick();
        check_eq("done_idle", {24'd0, irq_status}, 32'h0);

        // task_max gating
        task_max = 3'd1;
        pulse_trig(16'h0020);
        repeat (5) tick();
        check_eq("max_block", {31'd0, task_req}, 32'h0);
        task_max = 3'd4;
        pulse_trig(16'h0020);
        wait_req(20);
        check_eq("max_idx", {29'd0, task_idx}, 32'd4);
        check_eq("max_addr", {15'd0, task_desc_addr}, 32'h180);

        // reset while requesting
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("mid_rst_req", {31'd0, task_req}, 32'h0);
        check_eq("mid_rst_list", {24'd0, task_list}, 32'h0);
        check_eq("mid_rst_addr", {15'd0, task_desc_addr}, 32'h0);
        task_val = 8'h1F; task_load = 1'b1; tick(); task_load = 1'b0;
        repeat (4) tick();
        check_eq("mid_rst_pend", {31'd0, task_req}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
